// File: rtl/pc_fetch_stage_pkg.sv
// ============================================================================
// Module   : pc_fetch_stage_pkg
// Brief    : Shared constants and enums for the fetch stage and its next-PC mux.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_fetch_stage_pkg;

  localparam int          c_word_w    = 32;
  localparam logic [31:0] c_reset_pc  = 32'h0000_0000;
  localparam logic [31:0] c_halt_word = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD     = 2'd0,
    SEL_REDIRECT = 2'd1,
    SEL_HALT     = 2'd2,
    SEL_SEQ      = 2'd3
  } next_sel_e;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_stage_if.sv
// ============================================================================
// Module   : pc_fetch_stage_if
// Brief    : Control, instruction-memory and IF/ID bundle of the fetch stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_fetch_stage_if;
  import pc_fetch_stage_pkg::*;

  logic                stall;
  logic                branch_taken;
  logic [c_word_w-1:0] branch_addr;
  logic                jump;
  logic [c_word_w-1:0] jump_addr;
  logic                jr;
  logic [c_word_w-1:0] jr_addr;
  logic [c_word_w-1:0] imem_rdata;
  logic [c_word_w-1:0] imem_addr;
  logic [c_word_w-1:0] if_id_instruction;
  logic [c_word_w-1:0] if_id_pc_plus_4;
  logic                if_id_valid;
  logic                halted;
  logic                fetch_error;
  logic [c_word_w-1:0] fetch_count;

  // master is the fetch stage itself
  modport master (
    input  stall, branch_taken, branch_addr, jump, jump_addr, jr, jr_addr,
           imem_rdata,
    output imem_addr, if_id_instruction, if_id_pc_plus_4, if_id_valid,
           halted, fetch_error, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_addr, jump, jump_addr, jr, jr_addr,
           imem_rdata,
    input  imem_addr, if_id_instruction, if_id_pc_plus_4, if_id_valid,
           halted, fetch_error, fetch_count
  );

endinterface

`default_nettype wire

// File: rtl/pc_fetch_stage_next_pc_select.sv
// ============================================================================
// Module   : next_pc_select
// Brief    : Combinational next-PC priority mux with redirect alignment check.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module next_pc_select
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] HALT_WORD = c_halt_word
) (
  input  logic [c_word_w-1:0] i_pc,
  input  logic                i_stall,
  input  logic                i_jr,
  input  logic [c_word_w-1:0] i_jr_addr,
  input  logic                i_jump,
  input  logic [c_word_w-1:0] i_jump_addr,
  input  logic                i_branch_taken,
  input  logic [c_word_w-1:0] i_branch_addr,
  input  logic [c_word_w-1:0] i_imem_rdata,
  output next_sel_e           o_sel,
  output logic [c_word_w-1:0] o_target,
  output logic [c_word_w-1:0] o_pc_plus_4,
  output logic                o_misaligned
);

  logic [c_word_w-1:0] w_pc_plus_4;

  assign w_pc_plus_4 = i_pc + c_word_w'(4);
  assign o_pc_plus_4 = w_pc_plus_4;

  // stall > jr > jump > branch > halt detect > sequential
  always_comb begin
    o_sel    = SEL_SEQ;
    o_target = w_pc_plus_4;
    if (i_stall) begin
      o_sel    = SEL_HOLD;
      o_target = i_pc;
    end else if (i_jr) begin
      o_sel    = SEL_REDIRECT;
      o_target = i_jr_addr;
    end else if (i_jump) begin
      o_sel    = SEL_REDIRECT;
      o_target = i_jump_addr;
    end else if (i_branch_taken) begin
      o_sel    = SEL_REDIRECT;
      o_target = i_branch_addr;
    end else if (i_imem_rdata == HALT_WORD) begin
      o_sel    = SEL_HALT;
      o_target = i_pc;
    end
  end

  assign o_misaligned = (o_sel == SEL_REDIRECT) && (o_target[1:0] != 2'b00);

endmodule

`default_nettype wire

// File: rtl/pc_fetch_stage.sv
// ============================================================================
// Module   : pc_fetch_stage
// Brief    : PC register, IF/ID latch and RUN/HALTED fetch FSM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = c_reset_pc,
  parameter logic [31:0] HALT_WORD        = c_halt_word,
  parameter logic [31:0] FETCH_COUNT_INIT = 32'h0000_0000
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pc_fetch_stage_if.master  bus
);

  fetch_state_e        r_state;
  logic [c_word_w-1:0] r_pc;
  logic [c_word_w-1:0] r_instr;
  logic [c_word_w-1:0] r_pc_plus_4;
  logic                r_valid;
  logic                r_halted;
  logic                r_fetch_error;
  logic [c_word_w-1:0] r_fetch_count;

  next_sel_e           w_sel;
  logic [c_word_w-1:0] w_target;
  logic [c_word_w-1:0] w_pc_plus_4;
  logic                w_misaligned;

  next_pc_select #(
    .HALT_WORD (HALT_WORD)
  ) u_next_pc_select (
    .i_pc           (r_pc),
    .i_stall        (bus.stall),
    .i_jr           (bus.jr),
    .i_jr_addr      (bus.jr_addr),
    .i_jump         (bus.jump),
    .i_jump_addr    (bus.jump_addr),
    .i_branch_taken (bus.branch_taken),
    .i_branch_addr  (bus.branch_addr),
    .i_imem_rdata   (bus.imem_rdata),
    .o_sel          (w_sel),
    .o_target       (w_target),
    .o_pc_plus_4    (w_pc_plus_4),
    .o_misaligned   (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_pc_plus_4   <= '0;
      r_valid       <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_error <= 1'b0;
      r_fetch_count <= FETCH_COUNT_INIT;
    end else begin
      case (r_state)
        ST_RUN: begin
          case (w_sel)
            SEL_HOLD: ;
            SEL_REDIRECT: begin
              // the word fetched this cycle is on the wrong path
              r_valid <= 1'b0;
              if (w_misaligned) begin
                r_fetch_error <= 1'b1;
                r_halted      <= 1'b1;
                r_state       <= ST_HALTED;
              end else begin
                r_pc <= w_target;
              end
            end
            SEL_HALT: begin
              r_instr       <= bus.imem_rdata;
              r_pc_plus_4   <= w_pc_plus_4;
              r_valid       <= 1'b1;
              r_fetch_count <= r_fetch_count + c_word_w'(1);
              r_halted      <= 1'b1;
              r_state       <= ST_HALTED;
            end
            default: begin
              r_instr       <= bus.imem_rdata;
              r_pc_plus_4   <= w_pc_plus_4;
              r_valid       <= 1'b1;
              r_fetch_count <= r_fetch_count + c_word_w'(1);
              r_pc          <= w_target;
            end
          endcase
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr         = r_pc;
  assign bus.if_id_instruction = r_instr;
  assign bus.if_id_pc_plus_4   = r_pc_plus_4;
  assign bus.if_id_valid       = r_valid;
  assign bus.halted            = r_halted;
  assign bus.fetch_error       = r_fetch_error;
  assign bus.fetch_count       = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
// ============================================================================
// Module   : tb_pc_fetch_stage
// Brief    : Directed plus randomized bench for pc_fetch_stage against a model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_stage;

  localparam logic [31:0] c_halt = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt_en;
  logic [31:0] halt_addr;
  int          n_checks = 0;
  int          n_errors = 0;

  pc_fetch_stage_if bus ();
  pc_fetch_stage_if wrap_bus ();

  pc_fetch_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_fetch_stage #(
    .RESET_PC         (32'hFFFF_FFF8),
    .FETCH_COUNT_INIT (32'hFFFF_FFFE)
  ) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (wrap_bus)
  );

  always #5 clk = ~clk;

  // instruction memory: fixed words at 0 and 4, a hash elsewhere, optional halt word
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic he,
                                           input logic [31:0] ha);
    logic [31:0] w;
    if (he && a == ha) return c_halt;
    if (a == 32'h0) return 32'h2001_0005;
    if (a == 32'h4) return 32'h2002_0003;
    w = (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    if (w == c_halt) w = 32'h0;
    return w;
  endfunction

  assign bus.imem_rdata      = mem_word(bus.imem_addr, halt_en, halt_addr);
  assign wrap_bus.imem_rdata = mem_word(wrap_bus.imem_addr, 1'b0, 32'h0);

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_halted, m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [31:0] tgt, w;
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (bus.stall) begin
      // everything holds
    end else if (bus.jr || bus.jump || bus.branch_taken) begin
      tgt = bus.jr ? bus.jr_addr : (bus.jump ? bus.jump_addr : bus.branch_addr);
      m_valid = 1'b0;
      if (tgt % 4 != 0) begin
        m_err = 1'b1;
        m_halted = 1'b1;
      end else begin
        m_pc = tgt;
      end
    end else begin
      w = mem_word(m_pc, halt_en, halt_addr);
      m_instr = w;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_count = m_count + 32'd1;
      if (w == c_halt) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    check_eq("pc",       bus.imem_addr,         m_pc);
    check_eq("instr",    bus.if_id_instruction, m_instr);
    check_eq("pc4",      bus.if_id_pc_plus_4,   m_pc4);
    check_eq("valid",    32'(bus.if_id_valid),  32'(m_valid));
    check_eq("halted",   32'(bus.halted),       32'(m_halted));
    check_eq("ferr",     32'(bus.fetch_error),  32'(m_err));
    check_eq("count",    bus.fetch_count,       m_count);
  endtask

  task automatic clear_ctl();
    bus.stall = 1'b0; bus.jr = 1'b0; bus.jump = 1'b0; bus.branch_taken = 1'b0;
  endtask

  initial begin
    int halted_cycles;
    reset = 1'b1; halt_en = 1'b0; halt_addr = 32'h0;
    clear_ctl();
    bus.jr_addr = 32'h0; bus.jump_addr = 32'h0; bus.branch_addr = 32'h0;
    wrap_bus.stall = 1'b0; wrap_bus.jr = 1'b0; wrap_bus.jump = 1'b0;
    wrap_bus.branch_taken = 1'b0; wrap_bus.jr_addr = 32'h0;
    wrap_bus.jump_addr = 32'h0; wrap_bus.branch_addr = 32'h0;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0;

    // reset state, then first two fetches
    step();
    step();
    check_eq("rst_pc", bus.imem_addr, 32'h0);
    check_eq("rst_valid", 32'(bus.if_id_valid), 32'h0);
    reset = 1'b0;
    step();
    check_eq("seq_pc4_a", bus.if_id_pc_plus_4, 32'h4);
    check_eq("seq_instr_a", bus.if_id_instruction, 32'h2001_0005);
    step();
    check_eq("seq_pc4_b", bus.if_id_pc_plus_4, 32'h8);
    check_eq("seq_instr_b", bus.if_id_instruction, 32'h2002_0003);
    check_eq("seq_count", bus.fetch_count, 32'd2);
    check_eq("seq_addr", bus.imem_addr, 32'h8);

    // taken branch at pc 0x10
    step(); step();
    check_eq("br_at", bus.imem_addr, 32'h10);
    bus.branch_taken = 1'b1; bus.branch_addr = 32'h40;
    step();
    check_eq("br_pc", bus.imem_addr, 32'h40);
    check_eq("br_bubble", 32'(bus.if_id_valid), 32'h0);
    clear_ctl();
    step();
    check_eq("br_pc4", bus.if_id_pc_plus_4, 32'h44);
    check_eq("br_valid", 32'(bus.if_id_valid), 32'h1);

    // stall beats jr and jump, then jr wins over jump
    bus.stall = 1'b1; bus.jr = 1'b1; bus.jr_addr = 32'h80;
    bus.jump = 1'b1; bus.jump_addr = 32'h20;
    step();
    check_eq("stall_pc", bus.imem_addr, 32'h44);
    bus.stall = 1'b0;
    step();
    check_eq("jr_pc", bus.imem_addr, 32'h80);
    clear_ctl();

    // halt word at 0x0C; redirect afterwards is ignored
    reset = 1'b1; step(); reset = 1'b0;
    halt_en = 1'b1; halt_addr = 32'h0C;
    step(); step(); step();
    step();
    check_eq("halt_instr", bus.if_id_instruction, c_halt);
    check_eq("halt_flag", 32'(bus.halted), 32'h1);
    check_eq("halt_pc", bus.imem_addr, 32'h0C);
    bus.branch_taken = 1'b1; bus.branch_addr = 32'h40;
    step();
    check_eq("halt_bubble", 32'(bus.if_id_valid), 32'h0);
    check_eq("halt_hold", bus.imem_addr, 32'h0C);

    // misaligned branch target; reset also overrides a pending redirect
    reset = 1'b1; step(); reset = 1'b0;
    clear_ctl(); halt_en = 1'b0;
    step();
    bus.branch_taken = 1'b1; bus.branch_addr = 32'h42;
    step();
    check_eq("mis_err", 32'(bus.fetch_error), 32'h1);
    check_eq("mis_halt", 32'(bus.halted), 32'h1);
    check_eq("mis_pc", bus.imem_addr, 32'h4);
    reset = 1'b1; step(); reset = 1'b0;
    clear_ctl();
    check_eq("mis_clr", 32'(bus.fetch_error), 32'h0);
    check_eq("mis_rstpc", bus.imem_addr, 32'h0);

    // pc and fetch_count wrap on the preloaded instance
    reset = 1'b1; step();
    check_eq("wrap_rst_pc", wrap_bus.imem_addr, 32'hFFFF_FFF8);
    reset = 1'b0;
    step();
    check_eq("wrap_pc_a", wrap_bus.imem_addr, 32'hFFFF_FFFC);
    check_eq("wrap_cnt_a", wrap_bus.fetch_count, 32'hFFFF_FFFF);
    step();
    check_eq("wrap_pc_b", wrap_bus.imem_addr, 32'h0);
    check_eq("wrap_pc4_b", wrap_bus.if_id_pc_plus_4, 32'h0);
    check_eq("wrap_cnt_b", wrap_bus.fetch_count, 32'h0);

    // randomized traffic
    halted_cycles = 0;
    for (int i = 0; i < 800; i++) begin
      reset            = ($urandom_range(0, 99) < 2) || (halted_cycles > 8);
      bus.stall        = $urandom_range(0, 99) < 20;
      bus.jr           = $urandom_range(0, 99) < 8;
      bus.jump         = $urandom_range(0, 99) < 8;
      bus.branch_taken = $urandom_range(0, 99) < 10;
      bus.jr_addr      = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      bus.jump_addr    = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      bus.branch_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 99) < 4) bus.branch_addr[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 99) < 3) bus.jr_addr[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 99) < 5) begin
        halt_en   = $urandom_range(0, 1) == 1;
        halt_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      step();
      halted_cycles = m_halted ? halted_cycles + 1 : 0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF, SHALL be the instruction encoding that halts fetch.
REQ-003 Clock and reset are fixed: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 stall  in  1  hazard stall from decode; holds PC and IF/ID.
REQ-007 branch_taken  in  1  conditional branch resolved taken in ID.
REQ-008 branch_addr  in  32  branch target from the branch calculator.
REQ-009 jump  in  1  j/jal in ID.
REQ-010 jump_addr  in  32  j/jal target from the jump calculator.
REQ-011 jr  in  1  jr in ID.
REQ-012 jr_addr  in  32  register target from the jr calculator.
REQ-013 imem_rdata  in  32  instruction word at imem_addr, combinational read.
REQ-014 imem_addr  out  32  fetch address, equal to pc.
REQ-015 if_id_instruction  out  32  latched instruction for decode.
REQ-016 if_id_pc_plus_4  out  32  latched pc+4 for decode and the address calculators.
REQ-017 if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
REQ-018 halted  out  1  high in HALTED state.
REQ-019 fetch_error  out  1  sticky; a redirect target was not word-aligned.
REQ-020 fetch_count  out  32  number of valid instructions latched into IF/ID.

Function
REQ-021 FSM states: RUN, HALTED; RUN SHALL be the reset state.
REQ-022 pc_plus_4 SHALL be pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-023 RUN priority at each edge: stall > jr > jump > branch_taken > halt detect > sequential.
REQ-024 On stall: pc, IF/ID, and fetch_count SHALL hold; any simultaneous redirect is ignored, and decode SHALL re-present it.
REQ-025 On a redirect (jr/jump/branch_taken, no stall): pc SHALL load the selected target, and if_id_valid SHALL go 0 (the in-flight fetch is squashed; one-cycle penalty).
REQ-026 Redirect target with bits [1:0] != 0 SHALL set fetch_error, load no PC, clear if_id_valid, and enter HALTED.
REQ-027 Sequential, imem_rdata != HALT_WORD: IF/ID SHALL latch {imem_rdata, pc+4, valid=1}, pc SHALL load pc+4, and fetch_count SHALL increment.
REQ-028 imem_rdata == HALT_WORD: IF/ID SHALL latch it with valid=1, fetch_count SHALL increment, pc SHALL hold, and the FSM SHALL enter HALTED.
REQ-029 HALTED: pc SHALL hold; if_id_valid SHALL be 0 from the next edge; redirects and stall SHALL be ignored; only reset SHALL exit.
REQ-030 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 All outputs other than imem_addr SHALL be registered; imem_addr SHALL be combinational from pc.

Reset
REQ-032 Reset SHALL apply pc=RESET_PC, state=RUN, if_id_instruction=0, if_id_pc_plus_4=0, if_id_valid=0, fetch_error=0, and fetch_count=0.
REQ-033 Reset SHALL override stall, redirects, and HALTED in the same edge, including mid-stall and mid-redirect.
REQ-034 The first instruction SHALL be latched on the first edge after reset deasserts.

Structure
REQ-035 A shared cpu package SHALL hold the FSM state encoding, HALT_WORD, RESET_PC, and the 32-bit word width constant.
REQ-036 One sub-module, next_pc_select, SHALL implement the combinational priority mux and alignment check; registers and the FSM SHALL stay in pc_fetch_stage.

Verification
REQ-037 Reset, then imem returns 0x2001_0005, 0x2002_0003 -> if_id_pc_plus_4 = 4, then 8; fetch_count = 2; imem_addr = 8.
REQ-038 At pc=0x10, branch_taken=1 with branch_addr=0x40 -> next pc=0x40, if_id_valid=0 for one cycle; then the word at 0x40 is latched with if_id_pc_plus_4=0x44.
REQ-039 jr=1 (jr_addr=0x80), jump=1 (jump_addr=0x20), and stall=1 together -> pc unchanged; with stall dropped the next cycle -> pc=0x80.
REQ-040 imem_rdata=0xFFFF_FFFF at pc=0x0C -> if_id latches the halt word, halted=1, pc stays 0x0C, and if_id_valid=0 thereafter despite branch_taken=1.
REQ-041 branch_taken with branch_addr=0x42 -> fetch_error=1, halted=1, pc unchanged; reset -> fetch_error=0, pc=RESET_PC.
REQ-042 Preload pc near wrap with fetch_count=0xFFFF_FFFF -> pc wraps from 0xFFFF_FFFC to 0, and fetch_count wraps to 0.
